ecc_scrub_ctrl: RTL and testbench

ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

---
 rtl/ecc_scrub_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl -- background ECC memory scrubber.
//
// Walks the whole address range 0..2^AW-1, one read every INTERVAL idle
// cycles. Each read result from the external ECC decoder is classified:
//   clean               -> advance
//   single-bit (sec)    -> write the corrected word back, then advance
//   double-bit (ded)    -> count, raise sticky interrupt, advance (no write)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   scrub_en            level enable
//   irq_clr             pulse, clears ded_irq / ded_addr
//   mem_req/we/addr/wdata, mem_gnt   request/grant to the memory arbiter
//   rd_vld, rd_data, sec, ded        decoder result for a granted read
//   sec_cnt, ded_cnt    saturating error counters
//   ded_addr, ded_irq   first DED address since clear, sticky interrupt
//   pass_done           one-cycle pulse when the address wraps to 0
//   busy                controller is not idle
module ecc_scrub_ctrl #(
  parameter int DW       = 64,
  parameter int AW       = 10,
  parameter int INTERVAL = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scrub_en,
  input  logic          irq_clr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          rd_vld,
  input  logic [DW-1:0] rd_data,
  input  logic          sec,
  input  logic          ded,
  output logic [15:0]   sec_cnt,
  output logic [15:0]   ded_cnt,
  output logic [AW-1:0] ded_addr,
  output logic          ded_irq,
  output logic          pass_done,
  output logic          busy
);

  // Counter only ever holds INTERVAL-1 .. 0.
  localparam int            CW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(INTERVAL - 1);
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_RESP,
    S_WB
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg;
  logic [15:0]   sec_cnt_reg;
  logic [15:0]   ded_cnt_reg;
  logic [AW-1:0] ded_addr_reg;
  logic          ded_irq_reg;
  logic          pass_done_reg;

  logic          advance;   // current address finished, move to the next
  logic          wb_load;   // correctable error: capture data, go write back
  logic          ded_hit;   // uncorrectable error reported this cycle
  logic          wrap;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    advance    = 1'b0;
    wb_load    = 1'b0;
    ded_hit    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (scrub_en) begin
          state_next = S_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (!scrub_en) begin
          state_next = S_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = S_RD;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_RD: begin
        // Once issued, the read is always completed even if scrub_en drops.
        if (mem_gnt) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rd_vld) begin
          // DED wins over SEC: an uncorrectable word must never be written back.
          if (ded) begin
            ded_hit = 1'b1;
            advance = 1'b1;
          end else if (sec) begin
            wb_load    = 1'b1;
            state_next = S_WB;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_WB: begin
        if (mem_gnt) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (advance) begin
      if (scrub_en) begin
        state_next = S_WAIT;
        cnt_next   = CNT_LOAD;
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  assign wrap      = advance && (addr_reg == ADDR_LAST);
  assign addr_next = advance ? (addr_reg + AW'(1)) : addr_reg;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      sec_cnt_reg   <= '0;
      ded_cnt_reg   <= '0;
      ded_addr_reg  <= '0;
      ded_irq_reg   <= 1'b0;
      pass_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      pass_done_reg <= wrap;

      if (wb_load) begin
        wdata_reg <= rd_data;
        if (sec_cnt_reg != CNT_MAX) begin
          sec_cnt_reg <= sec_cnt_reg + 16'd1;
        end
      end

      // A new DED takes priority over a simultaneous clear so the event is
      // never lost; the clear still re-arms the address capture.
      if (ded_hit) begin
        if (ded_cnt_reg != CNT_MAX) begin
          ded_cnt_reg <= ded_cnt_reg + 16'd1;
        end
        ded_irq_reg <= 1'b1;
        if (!ded_irq_reg || irq_clr) begin
          ded_addr_reg <= addr_reg;
        end
      end else if (irq_clr) begin
        ded_irq_reg  <= 1'b0;
        ded_addr_reg <= '0;
      end
    end
  end

  // Request fields decode straight from registered state, so they are stable
  // for as long as the state waits for mem_gnt and drop right after it.
  assign mem_req   = (state_reg == S_RD) || (state_reg == S_WB);
  assign mem_we    = (state_reg == S_WB);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign sec_cnt   = sec_cnt_reg;
  assign ded_cnt   = ded_cnt_reg;
  assign ded_addr  = ded_addr_reg;
  assign ded_irq   = ded_irq_reg;
  assign pass_done = pass_done_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl -- directed bench for ecc_scrub_ctrl (INTERVAL=4, AW=2).
// A small memory/decoder responder grants requests and returns a per-address
// response table one cycle after each granted read; all grants are logged.
module tb_ecc_scrub_ctrl;

  localparam int DW = 64;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scrub_en = 1'b0;
  logic          irq_clr = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          rd_vld = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          sec = 1'b0;
  logic          ded = 1'b0;
  logic [15:0]   sec_cnt;
  logic [15:0]   ded_cnt;
  logic [AW-1:0] ded_addr;
  logic          ded_irq;
  logic          pass_done;
  logic          busy;

  ecc_scrub_ctrl #(.DW(DW), .AW(AW), .INTERVAL(4)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .irq_clr(irq_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .rd_vld(rd_vld),
    .rd_data(rd_data), .sec(sec), .ded(ded), .sec_cnt(sec_cnt),
    .ded_cnt(ded_cnt), .ded_addr(ded_addr), .ded_irq(ded_irq),
    .pass_done(pass_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Decoder response table, indexed by address
  logic [DW-1:0] rsp_data [4];
  logic          rsp_sec  [4];
  logic          rsp_ded  [4];
  logic          gnt_block = 1'b0;

  // Transaction logs
  int            rd_addr_q [$];
  int            rd_cyc_q  [$];
  int            wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            pass_cnt = 0;
  int            cyc = 0;

  // Responder: on every falling edge look at what the previous rising edge
  // accepted, return read data one cycle after a read grant, and set mem_gnt.
  initial begin
    logic          last_req, last_we, last_gnt;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    last_req = 1'b0; last_we = 1'b0; last_gnt = 1'b0;
    last_addr = '0; last_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pass_done) pass_cnt++;
      if (rst_n && last_req && last_gnt) begin
        if (last_we) begin
          wr_addr_q.push_back(int'(last_addr));
          wr_data_q.push_back(last_wdata);
          $display("[TB] cyc=%0d write addr=%0d data=%0h", cyc, last_addr, last_wdata);
        end else begin
          rd_addr_q.push_back(int'(last_addr));
          rd_cyc_q.push_back(cyc);
          $display("[TB] cyc=%0d read  addr=%0d", cyc, last_addr);
        end
      end
      if (rst_n && last_req && last_gnt && !last_we) begin
        rd_vld  = 1'b1;
        rd_data = rsp_data[last_addr];
        sec     = rsp_sec[last_addr];
        ded     = rsp_ded[last_addr];
      end else begin
        rd_vld  = 1'b0;
        rd_data = '0;
        sec     = 1'b0;
        ded     = 1'b0;
      end
      mem_gnt    = !gnt_block;
      last_req   = mem_req;
      last_we    = mem_we;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_gnt   = mem_gnt;
    end
  end

  task automatic wait_reads(input int n, input int budget, input string tag);
    int k = 0;
    while (rd_addr_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(rd_addr_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(busy), 64'(0));
  endtask

  task automatic clear_table();
    for (int i = 0; i < 4; i++) begin
      rsp_data[i] = 64'h0;
      rsp_sec[i]  = 1'b0;
      rsp_ded[i]  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            k;
    int            stable;
    logic [AW-1:0] saved_addr;
    logic [DW-1:0] saved_wdata;

    clear_table();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_req",   64'(mem_req),   64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_sec_cnt",   64'(sec_cnt),   64'(0));
    check("rst_ded_cnt",   64'(ded_cnt),   64'(0));
    check("rst_ded_irq",   64'(ded_irq),   64'(0));
    check("rst_mem_wdata", mem_wdata,      64'(0));
    check("rst_pass_done", 64'(pass_done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Clean pass over addresses 0..3
    scrub_en = 1'b1;
    wait_reads(4, 100, "p1_reads");
    check("p1_pass_not_early", 64'(pass_cnt), 64'(0));
    scrub_en = 1'b0;
    wait_idle(30, "p1_idle");
    for (int i = 0; i < 4; i++) check("p1_addr", 64'(rd_addr_q[i]), 64'(i));
    for (int i = 1; i < 4; i++) check("p1_gap_ge5", 64'(rd_cyc_q[i] - rd_cyc_q[i-1] >= 5), 64'(1));
    check("p1_pass_cnt", 64'(pass_cnt), 64'(1));
    check("p1_sec_cnt",  64'(sec_cnt),  64'(0));
    check("p1_ded_cnt",  64'(ded_cnt),  64'(0));
    check("p1_no_write", 64'(wr_addr_q.size()), 64'(0));

    // SEC at 1, SEC+DED at 2, DED at 3
    rsp_sec[1] = 1'b1; rsp_data[1] = 64'hDEAD_BEEF;
    rsp_sec[2] = 1'b1; rsp_ded[2] = 1'b1; rsp_data[2] = 64'h1111;
    rsp_ded[3] = 1'b1; rsp_data[3] = 64'h2222;
    scrub_en = 1'b1;
    wait_reads(8, 100, "p2_reads");
    scrub_en = 1'b0;
    wait_idle(30, "p2_idle");
    for (int i = 0; i < 4; i++) check("p2_addr", 64'(rd_addr_q[4+i]), 64'(i));
    check("p2_wr_count", 64'(wr_addr_q.size()), 64'(1));
    check("p2_wr_addr",  64'(wr_addr_q[0]), 64'(1));
    check("p2_wr_data",  wr_data_q[0], 64'hDEAD_BEEF);
    check("p2_sec_cnt",  64'(sec_cnt),  64'(1));
    check("p2_ded_cnt",  64'(ded_cnt),  64'(2));
    check("p2_ded_irq",  64'(ded_irq),  64'(1));
    check("p2_ded_addr", 64'(ded_addr), 64'(2));
    check("p2_pass_cnt", 64'(pass_cnt), 64'(2));
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    @(negedge clk);
    check("clr_ded_irq",  64'(ded_irq),  64'(0));
    check("clr_ded_addr", 64'(ded_addr), 64'(0));
    check("clr_ded_cnt",  64'(ded_cnt),  64'(2));

    // Grant stall at address 0
    clear_table();
    rsp_sec[1] = 1'b1; rsp_data[1] = 64'h1234_5678_9ABC_DEF0;
    rsp_sec[3] = 1'b1; rsp_data[3] = 64'hCAFE_F00D_0000_0003;
    gnt_block = 1'b1;
    scrub_en  = 1'b1;
    k = 0;
    while (!mem_req && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("st_req_seen", 64'(mem_req), 64'(1));
    check("st_addr", 64'(mem_addr), 64'(0));
    saved_addr  = mem_addr;
    saved_wdata = mem_wdata;
    n = rd_addr_q.size();
    stable = 0;
    repeat (7) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == saved_addr && mem_wdata == saved_wdata) stable++;
    end
    check("st_stable_cycles", 64'(stable), 64'(7));
    check("st_no_advance", 64'(rd_addr_q.size()), 64'(n));
    gnt_block = 1'b0;
    wait_reads(n + 1, 20, "st_release");
    check("st_read_addr", 64'(rd_addr_q[n]), 64'(0));

    // scrub_en dropped while waiting for the response of a SEC read
    k = 0;
    while (!(mem_req && !mem_we && mem_addr == 2'd1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("en_rd1_seen", 64'(mem_req), 64'(1));
    @(negedge clk);
    scrub_en = 1'b0;
    wait_idle(20, "en_idle");
    check("en_wr_count", 64'(wr_addr_q.size()), 64'(2));
    check("en_wr_addr",  64'(wr_addr_q[1]), 64'(1));
    check("en_wr_data",  wr_data_q[1], 64'h1234_5678_9ABC_DEF0);
    check("en_sec_cnt",  64'(sec_cnt), 64'(2));
    check("en_mem_req",  64'(mem_req), 64'(0));
    n = rd_addr_q.size();
    scrub_en = 1'b1;
    wait_reads(n + 1, 40, "en_resume");
    check("en_resume_addr", 64'(rd_addr_q[n]), 64'(2));

    // Reset pulse during the write-back of address 3
    k = 0;
    while (!(mem_req && mem_we) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wb_seen",     64'(mem_we),   64'(1));
    check("wb_addr",     64'(mem_addr), 64'(3));
    check("wb_sec_cnt",  64'(sec_cnt),  64'(3));
    rst_n = 1'b0;
    #1;
    check("ar_mem_req",   64'(mem_req),   64'(0));
    check("ar_mem_we",    64'(mem_we),    64'(0));
    check("ar_mem_addr",  64'(mem_addr),  64'(0));
    check("ar_mem_wdata", mem_wdata,      64'(0));
    check("ar_busy",      64'(busy),      64'(0));
    check("ar_sec_cnt",   64'(sec_cnt),   64'(0));
    check("ar_ded_cnt",   64'(ded_cnt),   64'(0));
    check("ar_ded_irq",   64'(ded_irq),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = rd_addr_q.size();
    wait_reads(n + 1, 40, "ar_restart");
    check("ar_restart_addr", 64'(rd_addr_q[n]), 64'(0));

    scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
